// File: rtl/cpu_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_bus_pkg
// Brief   : Shared CPU load/fetch bus encodings, responder states, lane helpers
// Revision: 1.0
// ============================================================================
package cpu_bus_pkg;

    localparam logic [1:0]  W_BYTE       = 2'd0;
    localparam logic [1:0]  W_SHORT      = 2'd1;
    localparam logic [1:0]  W_WORD       = 2'd2;
    localparam logic [1:0]  W_ILLEGAL    = 2'd3;
    localparam logic [31:0] RESET_VECTOR = 32'hb000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } resp_state_t;

    function automatic logic [3:0] lane_byte_enables(input logic [1:0] width,
                                                     input logic [1:0] lane);
        logic [3:0] be;
        be = 4'b0000;
        case (width)
            W_BYTE:  be = 4'b0001 << lane;
            W_SHORT: be = lane[1] ? 4'b1100 : 4'b0011;
            W_WORD:  be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

    // Shorts are always lane-aligned here, so a byte-granular shift covers both widths.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  width,
                                                 input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [31:0] res;
        shifted = word >> {lane, 3'b000};
        res     = 32'h0;
        case (width)
            W_BYTE:  res = {24'h0, shifted[7:0]};
            W_SHORT: res = {16'h0, shifted[15:0]};
            W_WORD:  res = word;
            default: res = 32'h0;
        endcase
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module  : bus_mem_responder_if
// Brief   : Request/response bus between CPU core and memory responder
// Revision: 1.0
// ============================================================================
interface bus_mem_responder_if;

    logic        i_req;
    logic        i_we;
    logic [1:0]  i_width;
    logic [31:0] i_addr;
    logic [31:0] i_wdata;
    logic [31:0] o_rdata;
    logic        o_ack;
    logic        o_err;
    logic        o_busy;

    modport master (
        output i_req, i_we, i_width, i_addr, i_wdata,
        input  o_rdata, o_ack, o_err, o_busy
    );

    modport slave (
        input  i_req, i_we, i_width, i_addr, i_wdata,
        output o_rdata, o_ack, o_err, o_busy
    );

endinterface
`default_nettype wire

// File: rtl/bus_mem_responder_ram.sv
`default_nettype none
// ============================================================================
// Module  : bus_ram_array
// Brief   : Single-port synchronous RAM, DEPTH_WORDS x 32 with byte enables
// Revision: 1.0
// ============================================================================
module bus_ram_array #(
    parameter int    DEPTH_WORDS = 1024,
    parameter int    ADDR_W      = 10,
    parameter string INIT_FILE   = ""
) (
    input  wire logic              clk,
    input  wire logic              i_en,
    input  wire logic              i_we,
    input  wire logic [3:0]        i_be,
    input  wire logic [ADDR_W-1:0] i_addr,
    input  wire logic [31:0]       i_wdata,
    output logic      [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int b = 0; b < 4; b++) begin
                if (i_we && i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : bus_mem_responder
// Brief   : One-at-a-time byte/short/word responder over on-chip block RAM
// Revision: 1.0
// ============================================================================
module bus_mem_responder
    import cpu_bus_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = RESET_VECTOR,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 0,
    parameter string       INIT_FILE   = ""
) (
    input  wire logic           clk,
    input  wire logic           reset,
    bus_mem_responder_if.slave  bus
);

    localparam int          c_AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] c_SPAN = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  c_WAIT = 4'(WAIT_STATES);

    resp_state_t r_state;
    resp_state_t w_next;
    logic        r_we;
    logic [1:0]  r_width;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_cnt;
    logic        r_err;
    logic        r_rd_ok;

    logic [31:0] w_offset;
    logic        w_in_range;
    logic        w_misaligned;
    logic        w_err;
    logic        w_access;
    logic [31:0] w_wdata_lanes;
    logic [31:0] w_ram_q;

    // Offset-based compare keeps the window check free of wrap at the top of the map.
    assign w_offset     = r_addr - BASE_ADDR;
    assign w_in_range   = (r_addr >= BASE_ADDR) && (w_offset < c_SPAN);
    assign w_misaligned = ((r_width == W_SHORT) && r_addr[0])
                       || ((r_width == W_WORD) && (r_addr[1:0] != 2'b00))
                       || (r_width == W_ILLEGAL);
    assign w_err        = !w_in_range || w_misaligned;
    assign w_access     = (r_state == ST_WAIT) && (r_cnt == 4'd0) && !reset;

    always_comb begin
        w_wdata_lanes = r_wdata;
        case (r_width)
            W_BYTE:  w_wdata_lanes = {4{r_wdata[7:0]}};
            W_SHORT: w_wdata_lanes = {2{r_wdata[15:0]}};
            default: w_wdata_lanes = r_wdata;
        endcase
    end

    bus_ram_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (c_AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk     (clk),
        .i_en    (w_access),
        .i_we    (r_we && !w_err),
        .i_be    (lane_byte_enables(r_width, r_addr[1:0])),
        .i_addr  (w_offset[c_AW+1:2]),
        .i_wdata (w_wdata_lanes),
        .o_rdata (w_ram_q)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (bus.i_req)        w_next = ST_WAIT;
            ST_WAIT: if (r_cnt == 4'd0)    w_next = ST_RESP;
            ST_RESP:                       w_next = ST_IDLE;
            default:                       w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
            r_err   <= 1'b0;
            r_rd_ok <= 1'b0;
        end else begin
            r_state <= w_next;
            if ((r_state == ST_IDLE) && bus.i_req) begin
                r_we    <= bus.i_we;
                r_width <= bus.i_width;
                r_addr  <= bus.i_addr;
                r_wdata <= bus.i_wdata;
                r_cnt   <= c_WAIT;
            end else if (r_state == ST_WAIT) begin
                if (r_cnt != 4'd0) begin
                    r_cnt <= r_cnt - 4'd1;
                end else begin
                    r_err   <= w_err;
                    r_rd_ok <= !w_err && !r_we;
                end
            end
        end
    end

    assign bus.o_ack   = (r_state == ST_RESP);
    assign bus.o_err   = (r_state == ST_RESP) && r_err;
    assign bus.o_busy  = (r_state != ST_IDLE);
    assign bus.o_rdata = ((r_state == ST_RESP) && r_rd_ok)
                       ? lane_extract(w_ram_q, r_width, r_addr[1:0]) : 32'h0;

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_bus_mem_responder
// Brief   : Scoreboard bench for bus_mem_responder at 0 and 3 wait states
// Revision: 1.0
// ============================================================================
module tb_bus_mem_responder;
    import cpu_bus_pkg::*;

    localparam logic [31:0] c_BASE = 32'hb000_0000;

    typedef struct {
        logic [31:0] d;
        logic        e;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0;
    logic        rst1;
    logic [1:0]  t_req;
    logic        t_we;
    logic [1:0]  t_width;
    logic [31:0] t_addr;
    logic [31:0] t_wdata;

    int   checks = 0;
    int   errors = 0;
    int   cyc    = 0;
    exp_t q0[$];
    exp_t q1[$];
    int   ack_cyc0[$];

    bus_mem_responder_if bus0 ();
    bus_mem_responder_if bus1 ();

    assign bus0.i_req   = t_req[0];
    assign bus0.i_we    = t_we;
    assign bus0.i_width = t_width;
    assign bus0.i_addr  = t_addr;
    assign bus0.i_wdata = t_wdata;
    assign bus1.i_req   = t_req[1];
    assign bus1.i_we    = t_we;
    assign bus1.i_width = t_width;
    assign bus1.i_addr  = t_addr;
    assign bus1.i_wdata = t_wdata;

    bus_mem_responder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(1024), .WAIT_STATES(0), .INIT_FILE(""))
        dut0 (.clk(clk), .reset(rst0), .bus(bus0));
    bus_mem_responder #(.BASE_ADDR(c_BASE), .DEPTH_WORDS(1024), .WAIT_STATES(3), .INIT_FILE(""))
        dut1 (.clk(clk), .reset(rst1), .bus(bus1));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus0.o_ack === 1'b1) begin
            ack_cyc0.push_back(cyc);
            checks++;
            if (q0.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack dut0: rdata=%h err=%b, required no ack", bus0.o_rdata, bus0.o_err);
            end else begin : pop0
                exp_t e;
                e = q0.pop_front();
                if (bus0.o_rdata !== e.d || bus0.o_err !== e.e) begin
                    errors++;
                    $display("FAIL resp dut0: rdata=%h err=%b, required rdata=%h err=%b", bus0.o_rdata, bus0.o_err, e.d, e.e);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus1.o_ack === 1'b1) begin
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL unexpected_ack dut1: rdata=%h err=%b, required no ack", bus1.o_rdata, bus1.o_err);
            end else begin : pop1
                exp_t e;
                e = q1.pop_front();
                if (bus1.o_rdata !== e.d || bus1.o_err !== e.e) begin
                    errors++;
                    $display("FAIL resp dut1: rdata=%h err=%b, required rdata=%h err=%b", bus1.o_rdata, bus1.o_err, e.d, e.e);
                end
            end
        end
    end

    function automatic logic dut_busy(input int d);
        return (d == 0) ? bus0.o_busy : bus1.o_busy;
    endfunction

    function automatic logic dut_ack(input int d);
        return (d == 0) ? bus0.o_ack : bus1.o_ack;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, act, req);
        end
    endtask

    // pulses: number of edges after acceptance that still see i_req high.
    task automatic issue(input int d, input logic we, input logic [1:0] w, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] ed, input logic ee, input int pulses);
        int   lat;
        int   busy_n;
        bit   seen;
        exp_t e;
        e.d = ed;
        e.e = ee;
        @(posedge clk); #1;
        t_we = we; t_width = w; t_addr = a; t_wdata = wd; t_req[d] = 1'b1;
        if (d == 0) q0.push_back(e); else q1.push_back(e);
        lat = 0; busy_n = 0; seen = 1'b0;
        while (!seen && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            t_req[d] = (lat <= pulses);
            if (dut_busy(d) === 1'b1) busy_n++;
            if (dut_ack(d) === 1'b1) seen = 1'b1;
        end
        @(posedge clk); #1;
        t_req[d] = 1'b0;
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout dut%0d addr=%h: no ack within 40 cycles, required ack", d, a);
        end else begin
            chk("ack_latency", 32'(lat), (d == 0) ? 32'd2 : 32'd5);
            chk("busy_cycles", 32'(busy_n), 32'(lat));
            chk("busy_clear", {31'h0, dut_busy(d)}, 32'h0);
        end
        if (pulses > 0) repeat (8) @(posedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        t_req = 2'b00; t_we = 1'b0; t_width = W_WORD; t_addr = 32'h0; t_wdata = 32'h0;
        rst0 = 1'b1; rst1 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst0 = 1'b0; rst1 = 1'b0;
        chk("reset_busy0",  {31'h0, bus0.o_busy}, 32'h0);
        chk("reset_ack0",   {31'h0, bus0.o_ack},  32'h0);
        chk("reset_err0",   {31'h0, bus0.o_err},  32'h0);
        chk("reset_rdata0", bus0.o_rdata,         32'h0);
        chk("reset_busy1",  {31'h0, bus1.o_busy}, 32'h0);

        // Basic word / byte / short traffic with zero wait states
        issue(0, 1'b1, W_WORD,  c_BASE,       32'h3010_0000, 32'h0,          1'b0, 0);
        issue(0, 1'b0, W_WORD,  c_BASE,       32'h0,         32'h3010_0000,  1'b0, 0);
        issue(0, 1'b1, W_WORD,  c_BASE + 4,   32'hcafe_babe, 32'h0,          1'b0, 0);
        issue(0, 1'b1, W_BYTE,  c_BASE + 5,   32'h1234_5611, 32'h0,          1'b0, 0);
        issue(0, 1'b0, W_WORD,  c_BASE + 4,   32'h0,         32'hcafe_11be,  1'b0, 0);
        issue(0, 1'b0, W_BYTE,  c_BASE + 7,   32'h0,         32'h0000_00ca,  1'b0, 0);
        issue(0, 1'b0, W_SHORT, c_BASE + 6,   32'h0,         32'h0000_cafe,  1'b0, 0);
        issue(0, 1'b0, W_SHORT, c_BASE + 4,   32'h0,         32'h0000_11be,  1'b0, 0);
        issue(0, 1'b1, W_SHORT, c_BASE + 6,   32'hffff_5566, 32'h0,          1'b0, 0);
        issue(0, 1'b0, W_WORD,  c_BASE + 4,   32'h0,         32'h5566_11be,  1'b0, 0);

        // Rejected accesses: none may touch the RAM
        issue(0, 1'b0, W_SHORT, c_BASE + 3,          32'h0,         32'h0, 1'b1, 0);
        issue(0, 1'b0, W_WORD,  32'hafff_ffff,       32'h0,         32'h0, 1'b1, 0);
        issue(0, 1'b0, W_WORD,  c_BASE + 32'h1000,   32'h0,         32'h0, 1'b1, 0);
        issue(0, 1'b1, W_WORD,  c_BASE + 6,          32'hdead_beef, 32'h0, 1'b1, 0);
        issue(0, 1'b1, W_WORD,  c_BASE + 32'h1004,   32'h0bad_f00d, 32'h0, 1'b1, 0);
        issue(0, 1'b1, W_ILLEGAL, c_BASE + 4,        32'h0bad_f00d, 32'h0, 1'b1, 0);
        issue(0, 1'b0, W_WORD,  c_BASE + 4,          32'h0,         32'h5566_11be, 1'b0, 0);

        // Top word of the window, byte lane 3
        issue(0, 1'b1, W_WORD,  c_BASE + 32'hffc, 32'h0000_0000, 32'h0,         1'b0, 0);
        issue(0, 1'b1, W_BYTE,  c_BASE + 32'hfff, 32'h0000_00a5, 32'h0,         1'b0, 0);
        issue(0, 1'b0, W_WORD,  c_BASE + 32'hffc, 32'h0,         32'ha500_0000, 1'b0, 0);

        // Reset landing on the access edge of a write drops the write
        @(posedge clk); #1;
        t_we = 1'b1; t_width = W_WORD; t_addr = c_BASE; t_wdata = 32'hffff_ffff; t_req[0] = 1'b1;
        @(posedge clk); #1;
        t_req[0] = 1'b0; rst0 = 1'b1;
        @(posedge clk); #1;
        rst0 = 1'b0;
        chk("abort_busy0", {31'h0, bus0.o_busy}, 32'h0);
        chk("abort_ack0",  {31'h0, bus0.o_ack},  32'h0);
        repeat (6) @(posedge clk);
        issue(0, 1'b0, W_WORD, c_BASE, 32'h0, 32'h3010_0000, 1'b0, 0);

        // Request held high: re-accepted every third cycle
        ack_cyc0.delete();
        for (int i = 0; i < 3; i++) q0.push_back('{d: 32'h3010_0000, e: 1'b0});
        @(posedge clk); #1;
        t_we = 1'b0; t_width = W_WORD; t_addr = c_BASE; t_req[0] = 1'b1;
        repeat (9) @(posedge clk);
        #1;
        t_req[0] = 1'b0;
        repeat (12) @(posedge clk);
        chk("held_ack_count", 32'(ack_cyc0.size()), 32'd3);
        if (ack_cyc0.size() == 3) begin
            chk("held_ack_gap1", 32'(ack_cyc0[1] - ack_cyc0[0]), 32'd3);
            chk("held_ack_gap2", 32'(ack_cyc0[2] - ack_cyc0[1]), 32'd3);
        end

        // Three wait states
        issue(1, 1'b1, W_WORD, c_BASE + 32'h10, 32'h1234_5678, 32'h0,         1'b0, 0);
        issue(1, 1'b0, W_WORD, c_BASE + 32'h10, 32'h0,         32'h1234_5678, 1'b0, 5);
        issue(1, 1'b0, W_BYTE, c_BASE + 32'h1000, 32'h0,       32'h0,         1'b1, 0);

        // Reset during WAIT of a write: no ack, word keeps its old value
        @(posedge clk); #1;
        t_we = 1'b1; t_width = W_WORD; t_addr = c_BASE + 32'h10; t_wdata = 32'hffff_ffff; t_req[1] = 1'b1;
        @(posedge clk); #1;
        t_req[1] = 1'b0;
        @(posedge clk); #1;
        rst1 = 1'b1;
        @(posedge clk); #1;
        rst1 = 1'b0;
        chk("abort_busy1", {31'h0, bus1.o_busy}, 32'h0);
        chk("abort_ack1",  {31'h0, bus1.o_ack},  32'h0);
        repeat (8) @(posedge clk);
        issue(1, 1'b0, W_WORD, c_BASE + 32'h10, 32'h0, 32'h1234_5678, 1'b0, 0);

        repeat (5) @(posedge clk);
        chk("q0_drained", 32'(q0.size()), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
